// File: rtl/aes_pkg.sv
// Shared constants and types for the AES round-key path.
package aes_pkg;

    localparam int KEY_W         = 128;
    localparam int NKEYS_DEFAULT = 10;
    localparam int IDX_W         = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        READY  = 2'd2,
        STREAM = 2'd3
    } state_t;

endpackage

// File: rtl/round_key_buffer_if.sv
// Round-key stream from the key buffer to the cipher round datapath.
// A beat transfers on a rising edge where rk_valid_o && rk_ready_i; while
// rk_valid_o && !rk_ready_i the payload (rk_o, rk_idx_o, last_o) is held
// stable. rk_valid_o only drops without an accept on a new key load or reset.
interface round_key_buffer_if;
    import aes_pkg::*;

    logic [KEY_W-1:0] rk_o;
    logic [IDX_W-1:0] rk_idx_o;
    logic             rk_valid_o;
    logic             rk_ready_i;
    logic             last_o;

    modport master (
        output rk_o, rk_idx_o, rk_valid_o, last_o,
        input  rk_ready_i
    );

    modport slave (
        input  rk_o, rk_idx_o, rk_valid_o, last_o,
        output rk_ready_i
    );

endinterface

// File: rtl/round_key_bank.sv
// NKEYS x KEY_W key register array: write-all strobe, one registered read port.
module round_key_bank
    import aes_pkg::*;
#(
    parameter int NKEYS = NKEYS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [NKEYS*KEY_W-1:0] wr_keys_i,
    input  logic                   rd_en_i,
    input  logic [IDX_W-1:0]       rd_idx_i,
    output logic [KEY_W-1:0]       rd_key_o
);

    logic [KEY_W-1:0] mem_q [NKEYS];
    logic [KEY_W-1:0] rd_key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NKEYS; i++) mem_q[i] <= '0;
            rd_key_q <= '0;
        end else begin
            if (wr_en_i) begin
                for (int i = 0; i < NKEYS; i++) mem_q[i] <= wr_keys_i[i*KEY_W +: KEY_W];
            end
            if (rd_en_i) rd_key_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_key_o = rd_key_q;

endmodule

// File: rtl/round_key_buffer.sv
// Captures the settled key-expansion outputs and streams them one per beat.
// Optional macro ROUND_KEY_REVERSE_EN enables descending (decryption) order via dir_i.
module round_key_buffer
    import aes_pkg::*;
#(
    parameter int NKEYS         = NKEYS_DEFAULT,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic [NKEYS*KEY_W-1:0] keys_i,
    input  logic                   start_i,
    input  logic                   dir_i,
    output logic                   keys_ready_o,
    output logic                   busy_o,
    output state_t                 state_o,
    round_key_buffer_if.master     rk
);

    localparam logic [IDX_W-1:0] MAX_IDX     = IDX_W'(NKEYS - 1);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             capture;
    logic             advance;
    logic [IDX_W-1:0] start_idx, start_final, next_idx, final_idx;

`ifdef ROUND_KEY_REVERSE_EN
    logic desc_q, desc_d;

    assign start_idx   = dir_i  ? MAX_IDX : '0;
    assign start_final = dir_i  ? '0 : MAX_IDX;
    assign next_idx    = desc_q ? idx_q - 1'b1 : idx_q + 1'b1;
    assign final_idx   = desc_q ? '0 : MAX_IDX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) desc_q <= 1'b0;
        else        desc_q <= desc_d;
    end
`else
    logic dir_unused;

    assign dir_unused  = dir_i;
    assign start_idx   = '0;
    assign start_final = MAX_IDX;
    assign next_idx    = idx_q + 1'b1;
    assign final_idx   = MAX_IDX;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    // A load overrides everything, including a start in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        capture = 1'b0;
        advance = 1'b0;
`ifdef ROUND_KEY_REVERSE_EN
        desc_d  = desc_q;
`endif
        if (load_i) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_INIT;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                SETTLE: begin
                    if (cnt_q == '0) begin
                        capture = 1'b1;
                        state_d = READY;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                READY: begin
                    if (start_i) begin
                        state_d = STREAM;
                        advance = 1'b1;
                        idx_d   = start_idx;
                        last_d  = (start_idx == start_final);
`ifdef ROUND_KEY_REVERSE_EN
                        desc_d  = dir_i;
`endif
                    end
                end
                STREAM: begin
                    if (rk.rk_ready_i) begin
                        if (last_q) begin
                            state_d = READY;
                        end else begin
                            advance = 1'b1;
                            idx_d   = next_idx;
                            last_d  = (next_idx == final_idx);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        keys_ready_o  = (state_q == READY);
        busy_o        = (state_q == SETTLE) || (state_q == STREAM);
        rk.rk_valid_o = (state_q == STREAM);
    end

    assign rk.rk_idx_o = idx_q;
    assign rk.last_o   = last_q;
    assign state_o     = state_q;

    // The bank read is issued with the next index so key and index land together.
    round_key_bank #(
        .NKEYS (NKEYS)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (capture),
        .wr_keys_i (keys_i),
        .rd_en_i   (advance),
        .rd_idx_i  (idx_d),
        .rd_key_o  (rk.rk_o)
    );

endmodule

// File: tb/tb_round_key_buffer.sv
// Self-checking bench for round_key_buffer; honours ROUND_KEY_REVERSE_EN when defined.
module tb_round_key_buffer;
    import aes_pkg::*;

    localparam int NK     = 10;
    localparam int SC     = 4;
    localparam int BEAT_W = 1 + IDX_W + KEY_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                load_i = 1'b0;
    logic                start_i = 1'b0;
    logic                dir_i = 1'b0;
    logic [NK*KEY_W-1:0] keys_i = '0;
    logic                keys_ready_o;
    logic                busy_o;
    state_t              state_o;

    round_key_buffer_if rk_if();

    round_key_buffer #(
        .NKEYS         (NK),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load_i),
        .keys_i       (keys_i),
        .start_i      (start_i),
        .dir_i        (dir_i),
        .keys_ready_o (keys_ready_o),
        .busy_o       (busy_o),
        .state_o      (state_o),
        .rk           (rk_if.master)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [KEY_W-1:0]  ref_bank  [NK];
    logic [KEY_W-1:0]  pend_bank [NK];
    logic [BEAT_W-1:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input bit fixed);
        logic [KEY_W-1:0] k;
        for (int i = 0; i < NK; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (fixed && i == 0) k = 128'h000102030405060708090a0b0c0d0e0f;
            if (fixed && i == 1) k = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
            if (fixed && i == 9) k = 128'h549932d1f08557681093ed9cbe2c974e;
            pend_bank[i] = k;
            keys_i[i*KEY_W +: KEY_W] = k;
        end
    endtask

    task automatic load_and_wait(input bit fixed, output int cyc);
        set_keys(fixed);
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        cyc = 1;
        while (!keys_ready_o && cyc < 40) begin
            tick();
            cyc++;
        end
        for (int i = 0; i < NK; i++) ref_bank[i] = pend_bank[i];
    endtask

    // Drives one stream and scores every accepted beat against the model order.
    task automatic do_stream(input bit dir, input int stall_pct, input int stall_idx,
                             input int stall_len, output int cycles);
        logic [BEAT_W-1:0] e, cur, held;
        bit rdy, eff_dir;
        int left, guard;
`ifdef ROUND_KEY_REVERSE_EN
        eff_dir = dir;
`else
        eff_dir = 1'b0;
`endif
        exp_q.delete();
        for (int i = 0; i < NK; i++) begin
            int k;
            k = eff_dir ? NK - 1 - i : i;
            exp_q.push_back({(i == NK - 1), IDX_W'(k), ref_bank[k]});
        end
        chk_cnt++;
        if (keys_ready_o !== 1'b1) $display("FAIL stream_pre keys_ready=%0b required 1", keys_ready_o);
        else pass_cnt++;
        start_i = 1'b1;
        dir_i   = dir;
        tick();
        start_i = 1'b0;
        dir_i   = 1'($urandom_range(0, 1));
        chk_cnt++;
        if ({rk_if.rk_valid_o, keys_ready_o, busy_o} !== 3'b101)
            $display("FAIL stream_start valid/ready/busy=%b required 101",
                     {rk_if.rk_valid_o, keys_ready_o, busy_o});
        else pass_cnt++;
        left = stall_len; cycles = 0; guard = 0; held = '0; rdy = 1'b1;
        while (exp_q.size() != 0 && guard < 200) begin
            cur = {rk_if.last_o, rk_if.rk_idx_o, rk_if.rk_o};
            if (!rdy) begin
                chk_cnt++;
                if (cur !== held) $display("FAIL stream_hold got %h required %h", cur, held);
                else pass_cnt++;
            end
            chk_cnt++;
            if (rk_if.rk_valid_o !== 1'b1) begin
                $display("FAIL stream_valid rk_valid=%0b required 1", rk_if.rk_valid_o);
                break;
            end
            pass_cnt++;
            if (int'(rk_if.rk_idx_o) == stall_idx && left > 0) begin
                rdy = 1'b0;
                left--;
            end else begin
                rdy = ($urandom_range(0, 99) >= stall_pct);
            end
            rk_if.rk_ready_i = rdy;
            if (rdy) begin
                e = exp_q.pop_front();
                chk_cnt++;
                if (cur !== e) $display("FAIL stream_beat got last/idx/key %h required %h", cur, e);
                else pass_cnt++;
            end else begin
                held = cur;
            end
            tick();
            cycles++;
            guard++;
        end
        rk_if.rk_ready_i = 1'b0;
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL stream_done beats_left=%0d required 0", exp_q.size());
        else pass_cnt++;
        chk_cnt++;
        if ({rk_if.rk_valid_o, keys_ready_o, state_o} !== {1'b0, 1'b1, READY})
            $display("FAIL stream_end valid/ready/state=%b required 0110",
                     {rk_if.rk_valid_o, keys_ready_o, state_o});
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({keys_ready_o, busy_o, rk_if.rk_valid_o, rk_if.last_o, rk_if.rk_idx_o, rk_if.rk_o} !== '0
            || state_o !== IDLE)
            $display("FAIL reset_outputs got nonzero outputs state=%0d required all 0", state_o);
        else pass_cnt++;
        repeat (3) tick();
        rst_n = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        chk_cnt++;
        if ({keys_ready_o, busy_o, rk_if.rk_valid_o} !== 3'b000 || state_o !== IDLE)
            $display("FAIL reset_idle_start ready/busy/valid=%b state=%0d required 000 IDLE",
                     {keys_ready_o, busy_o, rk_if.rk_valid_o}, state_o);
        else pass_cnt++;
    endtask

    task automatic test_capture();
        int cyc;
        set_keys(1'b1);
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        cyc = 1;
        while (!keys_ready_o && cyc < 40) begin
            chk_cnt++;
            if (busy_o !== 1'b1) $display("FAIL capture_busy cycle %0d busy=%0b required 1", cyc, busy_o);
            else pass_cnt++;
            tick();
            cyc++;
        end
        for (int i = 0; i < NK; i++) ref_bank[i] = pend_bank[i];
        chk_cnt++;
        if (cyc != SC + 1) $display("FAIL capture_latency got %0d cycles required %0d", cyc, SC + 1);
        else pass_cnt++;
    endtask

    task automatic test_stream_asc();
        int cycles;
        keys_i = {NK{$urandom(), $urandom(), $urandom(), $urandom()}};
        do_stream(1'b0, 0, -1, 0, cycles);
        chk_cnt++;
        if (cycles != NK) $display("FAIL asc_cycles got %0d required %0d", cycles, NK);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int cycles;
        do_stream(1'b0, 0, 4, 3, cycles);
        chk_cnt++;
        if (cycles != NK + 3) $display("FAIL bp_cycles got %0d required %0d", cycles, NK + 3);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cycles;
        do_stream(1'b0, 0, -1, 0, cycles);
        do_stream(1'($urandom_range(0, 1)), 0, -1, 0, cycles);
        chk_cnt++;
        if (cycles != NK) $display("FAIL b2b_cycles got %0d required %0d", cycles, NK);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int cyc, guard, cycles;
        start_i = 1'b1;
        dir_i   = 1'b0;
        tick();
        start_i = 1'b0;
        rk_if.rk_ready_i = 1'b1;
        guard = 0;
        while (rk_if.rk_idx_o != 4'd6 && guard < 20) begin
            tick();
            guard++;
        end
        set_keys(1'b0);
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        rk_if.rk_ready_i = 1'b0;
        chk_cnt++;
        if ({rk_if.rk_valid_o, busy_o} !== 2'b01)
            $display("FAIL abort_drop valid/busy=%b required 01", {rk_if.rk_valid_o, busy_o});
        else pass_cnt++;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cyc = 2;
        chk_cnt++;
        if (rk_if.rk_valid_o !== 1'b0 || state_o !== SETTLE)
            $display("FAIL abort_settle_start valid=%0b state=%0d required 0 SETTLE",
                     rk_if.rk_valid_o, state_o);
        else pass_cnt++;
        while (!keys_ready_o && cyc < 40) begin
            tick();
            cyc++;
        end
        for (int i = 0; i < NK; i++) ref_bank[i] = pend_bank[i];
        chk_cnt++;
        if (cyc != SC + 1) $display("FAIL abort_latency got %0d cycles required %0d", cyc, SC + 1);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (rk_if.rk_valid_o !== 1'b0 || state_o !== READY)
            $display("FAIL abort_no_queue valid=%0b state=%0d required 0 READY", rk_if.rk_valid_o, state_o);
        else pass_cnt++;
        do_stream(1'b0, 0, -1, 0, cycles);
    endtask

    task automatic test_load_start_same();
        int cyc;
        bit seen_valid;
        set_keys(1'b0);
        load_i  = 1'b1;
        start_i = 1'b1;
        tick();
        load_i  = 1'b0;
        start_i = 1'b0;
        chk_cnt++;
        if ({rk_if.rk_valid_o, busy_o, keys_ready_o} !== 3'b010 || state_o !== SETTLE)
            $display("FAIL same_cycle valid/busy/ready=%b state=%0d required 010 SETTLE",
                     {rk_if.rk_valid_o, busy_o, keys_ready_o}, state_o);
        else pass_cnt++;
        cyc = 1;
        seen_valid = 1'b0;
        while (!keys_ready_o && cyc < 40) begin
            tick();
            cyc++;
            if (rk_if.rk_valid_o) seen_valid = 1'b1;
        end
        tick();
        if (rk_if.rk_valid_o) seen_valid = 1'b1;
        for (int i = 0; i < NK; i++) ref_bank[i] = pend_bank[i];
        chk_cnt++;
        if (seen_valid || cyc != SC + 1)
            $display("FAIL same_cycle_stream seen_valid=%0b cycles=%0d required 0 %0d",
                     seen_valid, cyc, SC + 1);
        else pass_cnt++;
    endtask

    task automatic test_direction();
        int cycles;
        do_stream(1'b1, 0, -1, 0, cycles);
        do_stream(1'b0, 0, -1, 0, cycles);
        do_stream(1'b1, 25, -1, 0, cycles);
    endtask

    task automatic test_random();
        int cyc, cycles;
        for (int n = 0; n < 4; n++) begin
            load_and_wait(1'b0, cyc);
            chk_cnt++;
            if (cyc != SC + 1) $display("FAIL rand_latency got %0d required %0d", cyc, SC + 1);
            else pass_cnt++;
            do_stream(1'($urandom_range(0, 1)), 30, -1, 0, cycles);
        end
    endtask

    task automatic test_async_reset();
        int cyc, cycles;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        rk_if.rk_ready_i = 1'b1;
        repeat (3) tick();
        #3 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({keys_ready_o, busy_o, rk_if.rk_valid_o, rk_if.last_o, rk_if.rk_idx_o, rk_if.rk_o} !== '0
            || state_o !== IDLE)
            $display("FAIL async_reset got idx=%0d valid=%0b state=%0d required all 0",
                     rk_if.rk_idx_o, rk_if.rk_valid_o, state_o);
        else pass_cnt++;
        rk_if.rk_ready_i = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NK; i++) ref_bank[i] = '0;
        for (int i = 0; i < 5; i++) begin
            start_i = 1'($urandom_range(0, 1));
            tick();
            start_i = 1'b0;
            chk_cnt++;
            if ({keys_ready_o, rk_if.rk_valid_o} !== 2'b00)
                $display("FAIL post_reset ready/valid=%b required 00", {keys_ready_o, rk_if.rk_valid_o});
            else pass_cnt++;
        end
        load_and_wait(1'b0, cyc);
        do_stream(1'b0, 0, -1, 0, cycles);
    endtask

    initial begin
        rk_if.rk_ready_i = 1'b0;
        test_reset();
        test_capture();
        test_stream_asc();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_load_start_same();
        test_direction();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
